spi_reg_slave: RTL and testbench
================================

Name: spi_reg_slave

Overview:
- SPI register-write front end that drives the `SPI_ADDRESS` / `SPI_DATA` / `RISING_SS` bus consumed by all configuration blocks, for example output stream selection.
- It oversamples an external SPI mode-0 master on CLK and assembles 16-bit frames: address byte, then data byte, both MSB first.
- It publishes each completed frame with a one-cycle `RISING_SS` strobe.
- During the data phase it shifts out an 8-bit readback value on MISO.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer; legal range 2..3.
- FRAME_BITS, 16, bits per valid frame; fixed as address width plus data width.

Ports:
- CLK  in  1  system clock; must be at least 8x the SCK frequency.
- RST  in  1  synchronous reset, active-high.
- SCK  in  1  SPI clock from the master, asynchronous to CLK; idles low.
- SS_N  in  1  SPI slave select, active-low, asynchronous.
- MOSI  in  1  SPI serial data in, asynchronous.
- MISO  out  1  SPI serial data out.
- MISO_OE  out  1  MISO output enable; high while SS_N is low.
- READ_DATA  in  8  readback value, muxed externally by SPI_ADDRESS.
- SPI_ADDRESS  out  8  address byte of the current or last frame.
- SPI_DATA  out  8  data byte of the last valid frame.
- RISING_SS  out  1  one-CLK strobe marking a valid completed frame.
- FRAME_ERROR  out  1  one-CLK strobe when SS_N rises with a bit count other than 16.

Behaviour:
- Synchronization:
  - SCK, SS_N and MOSI each pass through SYNC_STAGES flip-flops.
  - sck_rise, sck_fall, ss_fall and ss_rise are single-cycle pulses taken from the synchronized values.
  - MOSI passes through the same depth as SCK, so sampling stays aligned.
- Reset (RST high at a CLK edge):
  - State goes to IDLE and the bit counter to 0.
  - SPI_ADDRESS = 8'h00, SPI_DATA = 8'h00, RISING_SS = 0, FRAME_ERROR = 0, MISO = 0, MISO_OE = 0.
  - Synchronizer flops reset to the idle level: SCK = 0, SS_N = 1.
  - Reset mid-frame discards the frame and produces no strobe.
- State machine:
  - IDLE -> ADDR on ss_fall. This clears the bit counter and the shift register and sets MISO_OE = 1.
  - ADDR: each sck_rise shifts in the synchronized MOSI and increments the counter. At count 8:
    - Load SPI_ADDRESS from the shift register; the data byte is not yet valid.
    - Go to DATA.
    - READ_DATA is captured into the transmit register 2 CLK cycles after SPI_ADDRESS updates, so the external mux has a settle cycle.
  - DATA:
    - Each sck_fall drives MISO from tx[7] and then shifts tx left.
    - Each sck_rise shifts in MOSI and increments the counter.
    - At count 16, the received byte goes into a data shadow register and the state goes to DONE.
  - DONE: further sck_rise edges still increment the counter, saturating at 31; no other effect.
  - Any state except IDLE, on ss_rise:
    - If count == 16: SPI_DATA <= shadow, with RISING_SS = 1 in the same cycle, which guarantees SPI_DATA is valid while the strobe is high.
    - Otherwise: FRAME_ERROR = 1, SPI_DATA unchanged, SPI_ADDRESS keeps whatever it last held.
    - Then go to IDLE and set MISO_OE = 0, MISO = 0.
- Output hold rules:
  - RISING_SS and FRAME_ERROR are each high for exactly one CLK.
  - SPI_ADDRESS and SPI_DATA hold until the next update.
- Latency:
  - The SS_N pin rising edge produces RISING_SS after SYNC_STAGES+1 CLK edges (3 with the default).
- Boundary conditions:
  - ss_rise and sck_rise in the same cycle: ss_rise wins and the bit is ignored.
  - ss_fall while not in IDLE (a glitch) restarts the frame at ADDR.
  - 0-bit frame (SS_N toggles with no SCK): FRAME_ERROR pulses.
  - Before the first sck_fall, MISO holds 0.

Decomposition:
- defines.v holds SPI_FRAME_BITS and the state encodings (IDLE, ADDR, DATA, DONE), alongside the existing ADDR_* register constants.
- One sub-module, sync_edge:
  - Parameterized SYNC_STAGES synchronizer plus rise/fall detector, with synchronous active-high reset and a reset-level parameter.
  - Instantiated for SCK and SS_N; MOSI uses a plain delay chain of the same depth.

Test Plan:
- Write A5h to address 07h (frame 16'h07A5, SCK = CLK/8) -> SPI_ADDRESS = 07h after the 8th bit; RISING_SS pulses once, 3 CLK after SS_N rises, with SPI_DATA = A5h in that cycle.
- Readback: READ_DATA = 3Ch whenever SPI_ADDRESS == 02h; send frame 16'h0200 -> MISO carries 0,0,1,1,1,1,0,0 on data-phase bits 9..16; MISO_OE is high only while SS_N is low.
- Short frame of 12 bits after a valid write of 55h -> FRAME_ERROR pulses once, RISING_SS stays low, SPI_DATA remains 55h.
- Long frame of 20 bits (16'h0311 followed by 4 extra bits) -> FRAME_ERROR pulses, no RISING_SS, SPI_DATA unchanged.
- Assert RST for one CLK after bit 10 of a frame, then release SS_N -> all outputs return to reset values; no RISING_SS and no FRAME_ERROR; the next full frame 16'h01FF completes normally with SPI_DATA = FFh.
- Back-to-back frames 16'h0001 and 16'h0002 with SS_N high for 4 CLK between them -> exactly two RISING_SS pulses, with SPI_DATA = 01h then 02h.

Source files
------------

// File: rtl/spi_reg_slave_pkg.sv
// Shared frame geometry and FSM state type for the SPI register-write front end.
package spi_reg_slave_pkg;

    localparam int unsigned SPI_FRAME_BITS = 16;
    localparam int unsigned SPI_ADDR_BITS  = 8;
    localparam int unsigned SPI_CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } spi_state_e;

endpackage

// File: rtl/spi_reg_slave_sync_edge.sv
// Multi-stage synchronizer with rise/fall pulse detection on the synchronized level.
module spi_reg_slave_sync_edge
    import spi_reg_slave_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   settle_q;
    logic                   lvl;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= {SYNC_STAGES{RST_VAL}};
            prev_q   <= RST_VAL;
            settle_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q   <= sync_q[SYNC_STAGES-1];
            settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are suppressed until the chain has refilled from the pin after reset,
    // so a pin already away from the reset level does not look like a fresh edge.
    assign lvl    = sync_q[SYNC_STAGES-1];
    assign rise_o = settle_q[SYNC_STAGES] &  lvl & ~prev_q;
    assign fall_o = settle_q[SYNC_STAGES] & ~lvl &  prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-write slave: oversampled 16-bit address/data frames with data-phase readback.
module spi_reg_slave
    import spi_reg_slave_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = SPI_FRAME_BITS
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCK,
    input  logic       SS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] READ_DATA,
    output logic [7:0] SPI_ADDRESS,
    output logic [7:0] SPI_DATA,
    output logic       RISING_SS,
    output logic       FRAME_ERROR
);

    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;

    spi_reg_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (SCK),
        .rise_o(sck_rise),
        .fall_o(sck_fall)
    );

    spi_reg_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (SS_N),
        .rise_o(ss_rise),
        .fall_o(ss_fall)
    );

    always_ff @(posedge CLK) begin
        if (RST) mosi_q <= '0;
        else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    spi_state_e           state_q;
    logic [SPI_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]           rx_q, rx_d;
    logic [7:0]           tx_q;
    logic [7:0]           shadow_q;
    logic [1:0]           cap_q;
    logic [7:0]           addr_q, data_q;
    logic                 rss_q, fe_q, miso_q, oe_q;

    always_comb begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        rx_d  = {rx_q[6:0], mosi_s};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            shadow_q <= '0;
            cap_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rss_q    <= 1'b0;
            fe_q     <= 1'b0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            rss_q <= 1'b0;
            fe_q  <= 1'b0;
            // Two-stage delay after the address update gives the external mux a settle cycle.
            cap_q <= {cap_q[0], 1'b0};
            if (cap_q[1]) tx_q <= READ_DATA;

            if (ss_fall) begin
                state_q <= ST_ADDR;
                cnt_q   <= '0;
                rx_q    <= '0;
                cap_q   <= '0;
                miso_q  <= 1'b0;
                oe_q    <= 1'b1;
            end else if (state_q != ST_IDLE) begin
                if (ss_rise) begin
                    if (cnt_q == SPI_CNT_W'(FRAME_BITS)) begin
                        data_q <= shadow_q;
                        rss_q  <= 1'b1;
                    end else begin
                        fe_q   <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                    miso_q  <= 1'b0;
                    oe_q    <= 1'b0;
                end else begin
                    if (sck_fall && state_q == ST_DATA) begin
                        miso_q <= tx_q[7];
                        tx_q   <= {tx_q[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        cnt_q <= cnt_d;
                        unique case (state_q)
                            ST_ADDR: begin
                                rx_q <= rx_d;
                                if (cnt_d == SPI_CNT_W'(SPI_ADDR_BITS)) begin
                                    addr_q  <= rx_d;
                                    cap_q   <= 2'b01;
                                    state_q <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                rx_q <= rx_d;
                                if (cnt_d == SPI_CNT_W'(FRAME_BITS)) begin
                                    shadow_q <= rx_d;
                                    state_q  <= ST_DONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign SPI_ADDRESS = addr_q;
    assign SPI_DATA    = data_q;
    assign RISING_SS   = rss_q;
    assign FRAME_ERROR = fe_q;
    assign MISO        = miso_q;
    assign MISO_OE     = oe_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: SPI master model at CLK/8 with strobe monitor.
module tb_spi_reg_slave;

    logic       CLK = 1'b0;
    logic       RST, SCK, SS_N, MOSI;
    logic       MISO, MISO_OE, RISING_SS, FRAME_ERROR;
    logic [7:0] READ_DATA, SPI_ADDRESS, SPI_DATA;

    always #5 CLK = ~CLK;

    spi_reg_slave #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SCK        (SCK),
        .SS_N       (SS_N),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .MISO_OE    (MISO_OE),
        .READ_DATA  (READ_DATA),
        .SPI_ADDRESS(SPI_ADDRESS),
        .SPI_DATA   (SPI_DATA),
        .RISING_SS  (RISING_SS),
        .FRAME_ERROR(FRAME_ERROR)
    );

    always_comb READ_DATA = (SPI_ADDRESS == 8'h02) ? 8'h3C : 8'h00;

    int unsigned n_cmp = 0, n_bad = 0;
    int unsigned cyc = 0, rss_cnt = 0, fe_cnt = 0, rss_cyc = 0, ss_cyc = 0;
    logic [7:0]  rss_data [$];
    logic [7:0]  miso_cap, addr8;
    logic        oe_mid;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST !== 1'b1) begin
            if (RISING_SS === 1'b1) begin
                rss_cnt++;
                rss_cyc = cyc;
                rss_data.push_back(SPI_DATA);
            end
            if (FRAME_ERROR === 1'b1) fe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mode-0 master: MOSI set while SCK low, half period of 4 CLKs.
    task automatic spi_xfer(input logic [31:0] bits, input int unsigned nbits,
                            input bit release_ss, input int unsigned gap);
        SS_N = 1'b0;
        repeat (4) @(negedge CLK);
        for (int unsigned i = 0; i < nbits; i++) begin
            MOSI = bits[nbits-1-i];
            repeat (4) @(negedge CLK);
            if (i >= 8 && i < 16) miso_cap[15-i] = MISO;
            if (i == 4) oe_mid = MISO_OE;
            SCK = 1'b1;
            repeat (4) @(negedge CLK);
            if (i == 7) addr8 = SPI_ADDRESS;
            SCK = 1'b0;
        end
        repeat (4) @(negedge CLK);
        if (release_ss) begin
            SS_N   = 1'b1;
            ss_cyc = cyc;
            repeat (gap) @(negedge CLK);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r0, f0;
        RST = 1'b1; SCK = 1'b0; SS_N = 1'b1; MOSI = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_addr", SPI_ADDRESS, 8'h00);
        check("rst_data", SPI_DATA, 8'h00);
        check("rst_rss", RISING_SS, 1'b0);
        check("rst_fe", FRAME_ERROR, 1'b0);
        check("rst_miso", MISO, 1'b0);
        check("rst_oe", MISO_OE, 1'b0);
        RST = 1'b0;
        repeat (6) @(negedge CLK);

        // Write A5h to address 07h
        r0 = rss_cnt; f0 = fe_cnt;
        spi_xfer(32'h07A5, 16, 1'b1, 10);
        check("wr_addr8", addr8, 8'h07);
        check("wr_oe_mid", oe_mid, 1'b1);
        check("wr_rss_cnt", rss_cnt - r0, 1);
        check("wr_rss_data", rss_data[$], 8'hA5);
        check("wr_latency", rss_cyc - ss_cyc, 3);
        check("wr_data_hold", SPI_DATA, 8'hA5);
        check("wr_fe_cnt", fe_cnt - f0, 0);
        check("wr_oe_after", MISO_OE, 1'b0);

        // Readback of address 02h
        spi_xfer(32'h0200, 16, 1'b1, 10);
        check("rb_miso", miso_cap, 8'h3C);
        check("rb_addr", SPI_ADDRESS, 8'h02);
        check("rb_data", SPI_DATA, 8'h00);
        check("rb_miso_idle", MISO, 1'b0);
        check("rb_oe_after", MISO_OE, 1'b0);

        // Valid write of 55h then a 12-bit frame
        spi_xfer(32'h0455, 16, 1'b1, 10);
        check("pre_short_data", SPI_DATA, 8'h55);
        r0 = rss_cnt; f0 = fe_cnt;
        spi_xfer(32'h0ABC, 12, 1'b1, 10);
        check("short_fe", fe_cnt - f0, 1);
        check("short_rss", rss_cnt - r0, 0);
        check("short_data", SPI_DATA, 8'h55);

        // 20-bit frame
        r0 = rss_cnt; f0 = fe_cnt;
        spi_xfer(32'h0311A, 20, 1'b1, 10);
        check("long_fe", fe_cnt - f0, 1);
        check("long_rss", rss_cnt - r0, 0);
        check("long_data", SPI_DATA, 8'h55);
        check("long_addr", SPI_ADDRESS, 8'h03);

        // SS_N toggle with no SCK
        r0 = rss_cnt; f0 = fe_cnt;
        spi_xfer(32'h0, 0, 1'b1, 10);
        check("zero_fe", fe_cnt - f0, 1);
        check("zero_rss", rss_cnt - r0, 0);

        // Reset after bit 10 of 16'h0622, then release SS_N
        r0 = rss_cnt; f0 = fe_cnt;
        spi_xfer(32'h018, 10, 1'b0, 0);
        check("mid_addr8", addr8, 8'h06);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        SS_N = 1'b1;
        repeat (10) @(negedge CLK);
        check("mrst_addr", SPI_ADDRESS, 8'h00);
        check("mrst_data", SPI_DATA, 8'h00);
        check("mrst_oe", MISO_OE, 1'b0);
        check("mrst_miso", MISO, 1'b0);
        check("mrst_rss", rss_cnt - r0, 0);
        check("mrst_fe", fe_cnt - f0, 0);
        spi_xfer(32'h01FF, 16, 1'b1, 10);
        check("post_rst_rss", rss_cnt - r0, 1);
        check("post_rst_data", SPI_DATA, 8'hFF);
        check("post_rst_addr", SPI_ADDRESS, 8'h01);

        // Back-to-back frames with 4 CLK gap
        r0 = rss_cnt; f0 = fe_cnt;
        spi_xfer(32'h0001, 16, 1'b1, 4);
        spi_xfer(32'h0002, 16, 1'b1, 10);
        check("b2b_rss", rss_cnt - r0, 2);
        check("b2b_fe", fe_cnt - f0, 0);
        check("b2b_first", rss_data[$-1], 8'h01);
        check("b2b_second", rss_data[$], 8'h02);
        check("b2b_hold", SPI_DATA, 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
